// File: rtl/hawk_cpu_lookup_arb.sv
// Round-robin arbiter that shares hawk's single CPU-lookup port between the
// read-stall and write-stall interceptors, and flags lookups that hang.
module hawk_cpu_lookup_arb #(
    parameter int ADDR_WIDTH     = 64,
    parameter int PPN_WIDTH      = ADDR_WIDTH - 12,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hawk_inactive,
    input  logic                 rd_req_valid,
    input  logic [PPN_WIDTH-1:0] rd_req_hppa,
    output logic                 rd_allow,
    output logic [PPN_WIDTH-1:0] rd_ppa,
    input  logic                 wr_req_valid,
    input  logic [PPN_WIDTH-1:0] wr_req_hppa,
    input  logic                 wr_req_zeroblk,
    output logic                 wr_allow,
    output logic [PPN_WIDTH-1:0] wr_ppa,
    output logic                 hawk_req_valid,
    output logic [PPN_WIDTH-1:0] hawk_req_hppa,
    output logic                 hawk_req_zeroblk,
    input  logic                 hawk_allow,
    input  logic [PPN_WIDTH-1:0] hawk_ppa,
    output logic                 timeout_err,
    input  logic                 err_clr,
    output logic [31:0]          lookup_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state_q;
    logic                 gnt_q;
    logic                 rr_q;
    logic [PPN_WIDTH-1:0] hppa_q;
    logic                 zeroblk_q;
    logic                 hawk_req_valid_q;
    logic                 timeout_err_q;
    logic [CNT_W-1:0]     tcnt_q;
    logic [31:0]          lookup_cnt_q;

    logic                 gnt_d;
    logic [PPN_WIDTH-1:0] hppa_d;
    logic                 zeroblk_d;
    logic                 complete;
    logic [PPN_WIDTH-1:0] ppa_sel;

    // Grant select (gnt 0 = rd, 1 = wr) and the same-cycle allow path back to
    // the owner; with hawk disabled the latched page is returned unchanged.
    always_comb begin
        gnt_d     = wr_req_valid && (!rd_req_valid || rr_q);
        hppa_d    = gnt_d ? wr_req_hppa : rd_req_hppa;
        zeroblk_d = gnt_d && wr_req_zeroblk;
        complete  = (state_q == LOOKUP) && (hawk_allow || hawk_inactive);
        ppa_sel   = hawk_allow ? hawk_ppa : hppa_q;
        rd_allow  = complete && !gnt_q;
        wr_allow  = complete && gnt_q;
        rd_ppa    = rd_allow ? ppa_sel : '0;
        wr_ppa    = wr_allow ? ppa_sel : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            gnt_q            <= 1'b0;
            rr_q             <= 1'b0;
            hppa_q           <= '0;
            zeroblk_q        <= 1'b0;
            hawk_req_valid_q <= 1'b0;
            timeout_err_q    <= 1'b0;
            tcnt_q           <= '0;
            lookup_cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_req_valid || wr_req_valid) begin
                        gnt_q            <= gnt_d;
                        hppa_q           <= hppa_d;
                        zeroblk_q        <= zeroblk_d;
                        hawk_req_valid_q <= 1'b1;
                        state_q          <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    // Saturate so a hung lookup keeps asserting the error.
                    if (tcnt_q != CNT_LAST) begin
                        tcnt_q <= tcnt_q + CNT_W'(1);
                    end
                    if (complete) begin
                        hawk_req_valid_q <= 1'b0;
                        lookup_cnt_q     <= lookup_cnt_q + 32'd1;
                        state_q          <= DONE;
                    end
                end
                DONE: begin
                    rr_q    <= ~gnt_q;
                    tcnt_q  <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if ((state_q == LOOKUP) && (tcnt_q == CNT_LAST)) begin
                timeout_err_q <= 1'b1;
            end else if (err_clr) begin
                timeout_err_q <= 1'b0;
            end
        end
    end

    assign hawk_req_valid   = hawk_req_valid_q;
    assign hawk_req_hppa    = hppa_q;
    assign hawk_req_zeroblk = zeroblk_q;
    assign timeout_err      = timeout_err_q;
    assign lookup_cnt       = lookup_cnt_q;

endmodule

// File: tb/tb_hawk_cpu_lookup_arb.sv
// Bench for hawk_cpu_lookup_arb: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hawk_cpu_lookup_arb;

    localparam int PPN  = 52;
    localparam int TOUT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            hawk_inactive;
    logic            rd_req_valid;
    logic [PPN-1:0]  rd_req_hppa;
    logic            rd_allow;
    logic [PPN-1:0]  rd_ppa;
    logic            wr_req_valid;
    logic [PPN-1:0]  wr_req_hppa;
    logic            wr_req_zeroblk;
    logic            wr_allow;
    logic [PPN-1:0]  wr_ppa;
    logic            hawk_req_valid;
    logic [PPN-1:0]  hawk_req_hppa;
    logic            hawk_req_zeroblk;
    logic            hawk_allow;
    logic [PPN-1:0]  hawk_ppa;
    logic            timeout_err;
    logic            err_clr;
    logic [31:0]     lookup_cnt;

    hawk_cpu_lookup_arb #(
        .ADDR_WIDTH    (64),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hawk_inactive   (hawk_inactive),
        .rd_req_valid    (rd_req_valid),
        .rd_req_hppa     (rd_req_hppa),
        .rd_allow        (rd_allow),
        .rd_ppa          (rd_ppa),
        .wr_req_valid    (wr_req_valid),
        .wr_req_hppa     (wr_req_hppa),
        .wr_req_zeroblk  (wr_req_zeroblk),
        .wr_allow        (wr_allow),
        .wr_ppa          (wr_ppa),
        .hawk_req_valid  (hawk_req_valid),
        .hawk_req_hppa   (hawk_req_hppa),
        .hawk_req_zeroblk(hawk_req_zeroblk),
        .hawk_allow      (hawk_allow),
        .hawk_ppa        (hawk_ppa),
        .timeout_err     (timeout_err),
        .err_clr         (err_clr),
        .lookup_cnt      (lookup_cnt)
    );

    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;
    int reqCycles   = 0;
    bit             obsWho[$];
    logic [63:0]    obsPpa[$];

    // Model: one lookup in flight at a time, a one-cycle cooldown after each
    // completion, and the next tie going to whoever was not served last.
    logic           mInFlight = 1'b0;
    logic           mCooldown = 1'b0;
    logic           mOwnerWr  = 1'b0;
    logic           mFavourWr = 1'b0;
    logic [PPN-1:0] mPage     = '0;
    logic           mZb       = 1'b0;
    int             mWaited   = 0;
    logic [31:0]    mCount    = '0;
    logic           mErr      = 1'b0;

    logic           expFinish;
    logic [PPN-1:0] expPpa;
    logic           pickWr;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rdV, input logic [PPN-1:0] rdH,
                                 input logic wrV, input logic [PPN-1:0] wrH, input logic wrZ,
                                 input logic hAllow, input logic [PPN-1:0] hPpa,
                                 input logic inact, input logic clr);
        rd_req_valid   = rdV;
        rd_req_hppa    = rdH;
        wr_req_valid   = wrV;
        wr_req_hppa    = wrH;
        wr_req_zeroblk = wrZ;
        hawk_allow     = hAllow;
        hawk_ppa       = hPpa;
        hawk_inactive  = inact;
        err_clr        = clr;
    endtask

    task automatic stepCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyReset();
        stepCycle();
        rst = 1'b1;
        applyStimulus(0, '0, 0, '0, 0, 0, '0, 0, 0);
        repeat (2) stepCycle();
        rst = 1'b0;
        stepCycle();
        obsWho.delete();
        obsPpa.delete();
        reqCycles = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mInFlight <= 1'b0;
            mCooldown <= 1'b0;
            mOwnerWr  <= 1'b0;
            mFavourWr <= 1'b0;
            mPage     <= '0;
            mZb       <= 1'b0;
            mWaited   <= 0;
            mCount    <= '0;
            mErr      <= 1'b0;
        end else begin
            if (mInFlight && (mWaited + 1 >= TOUT)) mErr <= 1'b1;
            else if (err_clr) mErr <= 1'b0;

            if (mInFlight) begin
                mWaited <= mWaited + 1;
                if (hawk_allow || hawk_inactive) begin
                    mInFlight <= 1'b0;
                    mCooldown <= 1'b1;
                    mCount    <= mCount + 32'd1;
                end
            end else if (mCooldown) begin
                mCooldown <= 1'b0;
                mWaited   <= 0;
                mFavourWr <= !mOwnerWr;
            end else if (rd_req_valid || wr_req_valid) begin
                pickWr     = wr_req_valid && (!rd_req_valid || mFavourWr);
                mOwnerWr  <= pickWr;
                mPage     <= pickWr ? wr_req_hppa : rd_req_hppa;
                mZb       <= pickWr && wr_req_zeroblk;
                mInFlight <= 1'b1;
            end
        end
    end

    // Compare every cycle, midway between input changes and the next edge.
    always @(negedge clk) begin
        #3;
        expFinish = mInFlight && (hawk_allow || hawk_inactive);
        expPpa    = hawk_allow ? hawk_ppa : mPage;
        checkOutput("hawk_req_valid", 64'(hawk_req_valid), 64'(mInFlight));
        if (mInFlight) begin
            checkOutput("hawk_req_hppa", 64'(hawk_req_hppa), 64'(mPage));
            checkOutput("hawk_req_zeroblk", 64'(hawk_req_zeroblk), 64'(mZb));
        end
        checkOutput("rd_allow", 64'(rd_allow), 64'(expFinish && !mOwnerWr));
        checkOutput("wr_allow", 64'(wr_allow), 64'(expFinish && mOwnerWr));
        checkOutput("rd_ppa", 64'(rd_ppa), (expFinish && !mOwnerWr) ? 64'(expPpa) : 64'd0);
        checkOutput("wr_ppa", 64'(wr_ppa), (expFinish && mOwnerWr) ? 64'(expPpa) : 64'd0);
        checkOutput("timeout_err", 64'(timeout_err), 64'(mErr));
        checkOutput("lookup_cnt", 64'(lookup_cnt), 64'(mCount));
        if (hawk_req_valid === 1'b1) reqCycles++;
        if (rd_allow === 1'b1) begin obsWho.push_back(1'b0); obsPpa.push_back(64'(rd_ppa)); end
        if (wr_allow === 1'b1) begin obsWho.push_back(1'b1); obsPpa.push_back(64'(wr_ppa)); end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit             found;
        logic [PPN-1:0] seenPpa;

        rst = 1'b1;
        applyStimulus(0, '0, 0, '0, 0, 0, '0, 0, 0);
        repeat (2) stepCycle();
        #2;
        checkOutput("reset hawk_req_valid", 64'(hawk_req_valid), 64'd0);
        checkOutput("reset hawk_req_hppa", 64'(hawk_req_hppa), 64'd0);
        checkOutput("reset timeout_err", 64'(timeout_err), 64'd0);
        checkOutput("reset lookup_cnt", 64'(lookup_cnt), 64'd0);
        applyReset();

        // Single rd lookup answered on the sixth LOOKUP cycle.
        applyStimulus(1, 52'h12345, 0, '0, 0, 0, '0, 0, 0);
        repeat (6) stepCycle();
        applyStimulus(1, 52'h12345, 0, '0, 0, 1, 52'h0ABCD, 0, 0);
        stepCycle();
        applyStimulus(0, '0, 0, '0, 0, 0, '0, 0, 0);
        #2;
        checkOutput("t1 req cycles", 64'(reqCycles), 64'd6);
        checkOutput("t1 lookup_cnt", 64'(lookup_cnt), 64'd1);
        checkOutput("t1 allow count", 64'(obsWho.size()), 64'd1);
        if (obsWho.size() == 1) begin
            checkOutput("t1 allow owner", 64'(obsWho[0]), 64'd0);
            checkOutput("t1 rd_ppa", obsPpa[0], 64'h0ABCD);
        end

        // Simultaneous requests from reset: rd, wr, rd.
        applyReset();
        applyStimulus(1, 52'h11111, 1, 52'h22222, 1, 1, 52'h0CAFE, 0, 0);
        repeat (4) stepCycle();
        #2;
        checkOutput("t2 wr hawk_req_valid", 64'(hawk_req_valid), 64'd1);
        checkOutput("t2 wr hppa", 64'(hawk_req_hppa), 64'h22222);
        checkOutput("t2 wr zeroblk", 64'(hawk_req_zeroblk), 64'd1);
        repeat (4) stepCycle();
        #2;
        checkOutput("t2 allow count", 64'(obsWho.size()), 64'd3);
        if (obsWho.size() >= 3) begin
            checkOutput("t2 order0", 64'(obsWho[0]), 64'd0);
            checkOutput("t2 order1", 64'(obsWho[1]), 64'd1);
            checkOutput("t2 order2", 64'(obsWho[2]), 64'd0);
        end
        applyStimulus(0, '0, 0, '0, 0, 0, '0, 0, 0);
        repeat (3) stepCycle();

        // Continuous contention with hawk answering at once: 8 strictly alternating.
        applyReset();
        applyStimulus(1, 52'h00AAA, 1, 52'h00BBB, 0, 1, 52'h0BEEF, 0, 0);
        repeat (23) stepCycle();
        applyStimulus(0, '0, 0, '0, 0, 0, '0, 0, 0);
        #2;
        checkOutput("t3 lookup_cnt", 64'(lookup_cnt), 64'd8);
        checkOutput("t3 allow count", 64'(obsWho.size()), 64'd8);
        for (int i = 0; i < obsWho.size() && i < 8; i++) begin
            checkOutput($sformatf("t3 order%0d", i), 64'(obsWho[i]), 64'(i % 2));
        end
        repeat (3) stepCycle();

        // Hawk disabled: identity mapping returned locally.
        applyReset();
        applyStimulus(0, '0, 1, 52'h00777, 0, 0, '0, 1, 0);
        found   = 1'b0;
        seenPpa = '0;
        for (int k = 0; k < 2 && !found; k++) begin
            stepCycle();
            #2;
            if (wr_allow === 1'b1) begin
                found   = 1'b1;
                seenPpa = wr_ppa;
            end
        end
        checkOutput("t4 wr_allow within 2", 64'(found), 64'd1);
        checkOutput("t4 wr_ppa", 64'(seenPpa), 64'h777);
        applyStimulus(0, '0, 0, '0, 0, 0, '0, 0, 0);
        repeat (3) stepCycle();

        // Timeout after 16 LOOKUP cycles, late completion, then clear.
        applyReset();
        applyStimulus(1, 52'h00042, 0, '0, 0, 0, '0, 0, 0);
        repeat (16) stepCycle();
        #2;
        checkOutput("t5 err before", 64'(timeout_err), 64'd0);
        stepCycle();
        #2;
        checkOutput("t5 err rises", 64'(timeout_err), 64'd1);
        repeat (8) stepCycle();
        #2;
        checkOutput("t5 err sticky", 64'(timeout_err), 64'd1);
        stepCycle();
        applyStimulus(1, 52'h00042, 0, '0, 0, 1, 52'h0DEAD, 0, 0);
        #2;
        checkOutput("t5 late rd_allow", 64'(rd_allow), 64'd1);
        checkOutput("t5 late rd_ppa", 64'(rd_ppa), 64'h0DEAD);
        stepCycle();
        applyStimulus(0, '0, 0, '0, 0, 0, '0, 0, 0);
        #2;
        checkOutput("t5 err after done", 64'(timeout_err), 64'd1);
        stepCycle();
        applyStimulus(0, '0, 0, '0, 0, 0, '0, 0, 1);
        stepCycle();
        applyStimulus(0, '0, 0, '0, 0, 0, '0, 0, 0);
        #2;
        checkOutput("t5 err cleared", 64'(timeout_err), 64'd0);

        // Reset in the third LOOKUP cycle, then a stray hawk response.
        applyReset();
        applyStimulus(1, 52'h00123, 0, '0, 0, 0, '0, 0, 0);
        repeat (3) stepCycle();
        rst = 1'b1;
        applyStimulus(0, '0, 0, '0, 0, 0, '0, 0, 0);
        #2;
        checkOutput("t6 reset req_valid", 64'(hawk_req_valid), 64'd0);
        checkOutput("t6 reset rd_allow", 64'(rd_allow), 64'd0);
        checkOutput("t6 reset hppa", 64'(hawk_req_hppa), 64'd0);
        stepCycle();
        rst = 1'b0;
        applyStimulus(0, '0, 0, '0, 0, 1, 52'h0F00D, 0, 0);
        repeat (3) stepCycle();
        applyStimulus(0, '0, 0, '0, 0, 0, '0, 0, 0);
        #2;
        checkOutput("t6 allow count", 64'(obsWho.size()), 64'd0);
        checkOutput("t6 lookup_cnt", 64'(lookup_cnt), 64'd0);
        repeat (2) stepCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/hawk_cpu_lookup_arb.md
Name: hawk_cpu_lookup_arb

Overview:
- Shares the single hawk CPU-lookup port between the read-stall and write-stall AXI interceptors.
- Each interceptor raises a lookup (host page number) while it holds a stalled transaction. The arbiter serialises these round-robin and forwards one lookup at a time to hawk.
- It routes hawk's allow/PPA override back only to the granted requester, and watches for lookups that never complete.

Parameters:
- ADDR_WIDTH, 64, AXI address width.
- PPN_WIDTH, ADDR_WIDTH-12, page-number width (4KB pages).
- TIMEOUT_CYCLES, 4096, LOOKUP-state cycles before the timeout error is flagged.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- hawk_inactive  in  1  hawk disabled; lookups answered locally with identity mapping
- rd_req_valid  in  1  read-stall lookup request; level, held until its allow
- rd_req_hppa  in  PPN_WIDTH  read-stall host page number
- rd_allow  out  1  one-cycle allow pulse to read-stall path
- rd_ppa  out  PPN_WIDTH  translated page for read-stall path; valid with rd_allow
- wr_req_valid  in  1  write-stall lookup request; level
- wr_req_hppa  in  PPN_WIDTH  write-stall host page number
- wr_req_zeroblk  in  1  write-stall zero-block-write hint
- wr_allow  out  1  one-cycle allow pulse to write-stall path
- wr_ppa  out  PPN_WIDTH  translated page for write-stall path; valid with wr_allow
- hawk_req_valid  out  1  lookup request to hawk
- hawk_req_hppa  out  PPN_WIDTH  page to look up
- hawk_req_zeroblk  out  1  zero-block hint (forced 0 for rd grants)
- hawk_allow  in  1  hawk override pulse (allow_access)
- hawk_ppa  in  PPN_WIDTH  hawk override PPA; valid with hawk_allow
- timeout_err  out  1  sticky; a lookup exceeded TIMEOUT_CYCLES
- err_clr  in  1  clears timeout_err
- lookup_cnt  out  32  completed-lookup counter; wraps

Behaviour:
- Reset values:
  - state=IDLE; rr_ptr=0 (rd preferred).
  - All outputs 0, including hawk_req_*, rd/wr_allow, rd/wr_ppa, timeout_err, lookup_cnt.
  - Latched hppa/zeroblk/grant=0.
- States: IDLE, LOOKUP, DONE.
- IDLE:
  - If either valid is high, grant per rr_ptr: if both are valid, the requester pointed to wins; if only one, it wins.
  - Latch grant, hppa, and zeroblk (0 for rd). Go to LOOKUP next cycle.
  - If no valid, stay in IDLE.
- LOOKUP:
  - hawk_req_valid=1 and hawk_req_hppa/zeroblk=latched values, all registered and stable throughout the state.
  - The timeout counter increments each cycle.
  - On hawk_allow=1:
    - Same cycle, combinationally: {gnt}_allow=1 and {gnt}_ppa=hawk_ppa. The other requester's allow stays 0.
    - Next cycle: state goes to DONE, hawk_req_valid drops, and lookup_cnt increments.
  - If hawk_inactive=1 while in LOOKUP (and no hawk_allow):
    - {gnt}_allow=1 and {gnt}_ppa=latched hppa.
    - Go to DONE; lookup_cnt increments.
  - hawk_allow takes priority over hawk_inactive in the same cycle.
- DONE:
  - One bubble cycle so the requester can drop its valid.
  - rr_ptr toggles to point at the non-granted requester; timeout counter clears; go to IDLE.
  - The next grant is therefore ≥2 cycles after the allow.
- A hawk_allow outside LOOKUP is ignored: no allow output, and not counted.
- Requester drops valid mid-LOOKUP: lookup continues; the allow pulse is still delivered to that requester and it must ignore it.
- Timeout:
  - When the counter reaches TIMEOUT_CYCLES-1 in LOOKUP, set timeout_err (sticky). Keep waiting; no abort.
  - err_clr clears it. If err_clr and a set condition occur in the same cycle, set wins.
- hawk_inactive in IDLE:
  - Arbitration proceeds normally.
  - Grant then completes in LOOKUP on its first cycle, with identity PPA.
- lookup_cnt wraps 0xFFFFFFFF→0.
- Async reset mid-LOOKUP: returns to IDLE and drops hawk_req_valid immediately. A hawk response arriving after reset is ignored.

Test Plan:
- Single rd request, hppa=0x12345; hawk_allow after 5 cycles with ppa=0x0ABCD:
  - hawk_req_valid high for 6 cycles with hppa=0x12345.
  - rd_allow pulses 1 cycle with rd_ppa=0x0ABCD; wr_allow stays 0; lookup_cnt=1.
- rd and wr valid in the same cycle from reset:
  - rd granted first.
  - After rd's allow and DONE, wr is granted (hppa=wr value, zeroblk=wr_req_zeroblk).
  - If rd re-requests immediately, the order is rd, wr, rd.
- Continuous rd and wr requests, hawk answers each in 1 cycle: grants alternate strictly across 8 lookups; lookup_cnt=8.
- hawk_inactive=1, wr request hppa=0x00777: wr_allow with wr_ppa=0x00777 at most 2 cycles after wr_req_valid; hawk_allow never needed.
- TIMEOUT_CYCLES=16 and no hawk response:
  - timeout_err rises after 16 LOOKUP cycles and persists.
  - A later hawk_allow completes normally; err_clr then drops timeout_err.
- Reset asserted in cycle 3 of LOOKUP, then a hawk_allow: all outputs 0 immediately; no allow pulse emitted; lookup_cnt=0.
